// File: rtl/move_input_if.sv
// rtl/move_input_if.sv - push-button inputs and move/pressed outputs of move_input
interface move_input_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_reset;
    logic [2:0] move;
    logic [4:0] pressed;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_reset,
        input  move, pressed
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_reset,
        output move, pressed
    );
endinterface

// File: rtl/move_input.sv
// rtl/move_input.sv - synchronize, debounce and encode push-buttons into one-cycle move codes
// Optional auto-repeat of a single held direction button: define AUTO_REPEAT_EN.
module move_input #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic         clk,
    input  logic         rst,
    move_input_if.slave  io
);
    localparam logic [2:0] MOVE_NONE  = 3'd0;
    localparam logic [2:0] MOVE_UP    = 3'd1;
    localparam logic [2:0] MOVE_DOWN  = 3'd2;
    localparam logic [2:0] MOVE_LEFT  = 3'd3;
    localparam logic [2:0] MOVE_RIGHT = 3'd4;
    localparam logic [2:0] MOVE_RESET = 3'd5;

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // Bit order everywhere: {reset, right, left, down, up}
    logic [4:0]    raw;
    logic [4:0]    sync1_q, sync2_q;
    logic [4:0]    deb_q, deb_d;
    logic [DW-1:0] cnt_q [5];
    logic [DW-1:0] cnt_d [5];
    logic [4:0]    pressed_q, prev_q;
    logic [2:0]    move_q, move_d;
    logic [4:0]    rise;
    logic [4:0]    rpt_mask;
    logic [4:0]    ev;

    assign raw = {io.btn_reset, io.btn_right, io.btn_left, io.btn_down, io.btn_up};

    // A level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise = pressed_q & ~prev_q;

`ifdef AUTO_REPEAT_EN
    localparam int RDW = (REPEAT_DELAY  > 1) ? $clog2(REPEAT_DELAY)  : 1;
    localparam int RPW = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
    localparam int RW  = (RDW > RPW) ? RDW : RPW;

    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_periodic_q, rpt_periodic_d;
    logic [3:0]    dirs;
    logic          single_dir;
    logic [RW-1:0] rpt_target;
    logic          rpt_fire;

    assign dirs       = pressed_q[3:0];
    assign single_dir = (dirs != 4'd0) && ((dirs & 4'(dirs - 4'd1)) == 4'd0);
    assign rpt_target = rpt_periodic_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);

    // Any change of the debounced set restarts the hold timer from the delay phase
    always_comb begin
        rpt_cnt_d      = rpt_cnt_q;
        rpt_periodic_d = rpt_periodic_q;
        rpt_fire       = 1'b0;
        if (pressed_q != prev_q) begin
            rpt_cnt_d      = '0;
            rpt_periodic_d = 1'b0;
        end else if (single_dir) begin
            if (rpt_cnt_q == rpt_target) begin
                rpt_fire       = 1'b1;
                rpt_cnt_d      = '0;
                rpt_periodic_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end else begin
            rpt_cnt_d = '0;
        end
    end

    assign rpt_mask = rpt_fire ? {1'b0, dirs} : 5'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt_q      <= '0;
            rpt_periodic_q <= 1'b0;
        end else begin
            rpt_cnt_q      <= rpt_cnt_d;
            rpt_periodic_q <= rpt_periodic_d;
        end
    end
`else
    assign rpt_mask = 5'd0;
`endif

    assign ev = rise | rpt_mask;

    always_comb begin
        move_d = MOVE_NONE;
        if (ev[4])      move_d = MOVE_RESET;
        else if (ev[0]) move_d = MOVE_UP;
        else if (ev[1]) move_d = MOVE_DOWN;
        else if (ev[2]) move_d = MOVE_LEFT;
        else if (ev[3]) move_d = MOVE_RIGHT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            pressed_q <= '0;
            prev_q    <= '0;
            move_q    <= MOVE_NONE;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            pressed_q <= deb_q;
            prev_q    <= pressed_q;
            move_q    <= move_d;
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign io.move    = move_q;
    assign io.pressed = pressed_q;
endmodule
